// File: rtl/axis_pkg.sv
// Shared AXI4-Stream definitions: default sideband widths and the packed beat record
// that both the FIFO storage and any other axis_if user carry around.
package axis_pkg;

  localparam int AXIS_TDATA_BYTES = 4;
  localparam int AXIS_TID_BITS    = 1;
  localparam int AXIS_TDEST_BITS  = 1;
  localparam int AXIS_TUSER_BITS  = 1;
  localparam int AXIS_TDATA_BITS  = AXIS_TDATA_BYTES * 8;
  localparam int AXIS_BEAT_BITS   = AXIS_TDATA_BITS + 2 * AXIS_TDATA_BYTES + 1 +
                                    AXIS_TID_BITS + AXIS_TDEST_BITS + AXIS_TUSER_BITS;

  typedef struct packed {
    logic [AXIS_TDATA_BITS-1:0]  data;
    logic [AXIS_TDATA_BYTES-1:0] strb;
    logic [AXIS_TDATA_BYTES-1:0] keep;
    logic                        last;
    logic [AXIS_TID_BITS-1:0]    id;
    logic [AXIS_TDEST_BITS-1:0]  dest;
    logic [AXIS_TUSER_BITS-1:0]  user;
  } axis_beat_t;

  // Pointer width including the wrap bit.
  function automatic int axis_ptr_bits(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/axis_if.sv
// AXI4-Stream bundle with every sideband; master drives tvalid/payload, slave drives tready.
interface axis_if #(
  parameter int TDATA_BYTES = 4,
  parameter int TID_BITS    = 1,
  parameter int TDEST_BITS  = 1,
  parameter int TUSER_BITS  = 1
) ();

  logic                     tvalid;
  logic                     tready;
  logic [TDATA_BYTES*8-1:0] tdata;
  logic [TDATA_BYTES-1:0]   tstrb;
  logic [TDATA_BYTES-1:0]   tkeep;
  logic                     tlast;
  logic [TID_BITS-1:0]      tid;
  logic [TDEST_BITS-1:0]    tdest;
  logic [TUSER_BITS-1:0]    tuser;

  modport master (
    output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
    output tready
  );

endinterface

// File: rtl/axis_fifo_ram.sv
// Beat storage for axis_fifo: one synchronous write port, one asynchronous read port
// so the head entry is presented combinationally (first-word-fall-through).
module axis_fifo_ram
  import axis_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  axis_beat_t    wr_beat,
  input  logic [AW-1:0] rd_addr,
  output axis_beat_t    rd_beat
);

  axis_beat_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_beat;
    end
  end

  assign rd_beat = mem[rd_addr];

endmodule

// File: rtl/axis_fifo.sv
// Synchronous AXI4-Stream FIFO with fill-level status. Defining AXIS_FIFO_PACKET_MODE_EN
// turns it into a store-and-forward packet FIFO with a cut-through escape when full.
module axis_fifo
  import axis_pkg::*;
#(
  parameter  int TDATA_BYTES = AXIS_TDATA_BYTES,
  parameter  int TID_BITS    = AXIS_TID_BITS,
  parameter  int TDEST_BITS  = AXIS_TDEST_BITS,
  parameter  int TUSER_BITS  = AXIS_TUSER_BITS,
  parameter  int DEPTH       = 16,
  localparam int AW          = $clog2(DEPTH),
  localparam int PW          = axis_ptr_bits(DEPTH)
) (
  input  logic          aclk,
  input  logic          aresetn,
  axis_if.slave         s_axis,
  axis_if.master        m_axis,
  output logic [PW-1:0] fill_count,
  output logic          full,
  output logic          empty
);

  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic          ready_reg;
  logic          wr_en;
  logic          rd_en;
  axis_beat_t    wr_beat;
  axis_beat_t    rd_beat;

  assign full       = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                      (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
  assign empty      = (wr_ptr_reg == rd_ptr_reg);
  assign fill_count = wr_ptr_reg - rd_ptr_reg;

  // ready_reg holds tready low through reset and for the release cycle.
  assign s_axis.tready = ready_reg && !full;
  assign wr_en         = s_axis.tvalid && s_axis.tready;
  assign rd_en         = m_axis.tvalid && m_axis.tready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      ready_reg  <= 1'b0;
    end else begin
      ready_reg <= 1'b1;
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (rd_en) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

  always_comb begin
    wr_beat      = '0;
    wr_beat.data = s_axis.tdata;
    wr_beat.strb = s_axis.tstrb;
    wr_beat.keep = s_axis.tkeep;
    wr_beat.last = s_axis.tlast;
    wr_beat.id   = s_axis.tid;
    wr_beat.dest = s_axis.tdest;
    wr_beat.user = s_axis.tuser;
  end

  axis_fifo_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (aclk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_reg[AW-1:0]),
    .wr_beat (wr_beat),
    .rd_addr (rd_ptr_reg[AW-1:0]),
    .rd_beat (rd_beat)
  );

`ifdef AXIS_FIFO_PACKET_MODE_EN
  logic [PW-1:0] pkt_count_reg;
  logic          cut_reg;
  logic          cut_start;
  logic          wr_last;
  logic          rd_last;

  assign wr_last   = wr_en && s_axis.tlast;
  assign rd_last   = rd_en && rd_beat.last;
  // A full FIFO with no complete packet can never finish one; stream it out instead.
  assign cut_start = full && (pkt_count_reg == '0);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pkt_count_reg <= '0;
      cut_reg       <= 1'b0;
    end else begin
      if (wr_last && !rd_last) begin
        pkt_count_reg <= pkt_count_reg + 1'b1;
      end else if (!wr_last && rd_last) begin
        pkt_count_reg <= pkt_count_reg - 1'b1;
      end
      if (rd_last) begin
        cut_reg <= 1'b0;
      end else if (cut_start) begin
        cut_reg <= 1'b1;
      end
    end
  end

  assign m_axis.tvalid = !empty && ((pkt_count_reg != '0) || cut_reg || cut_start);
`else
  assign m_axis.tvalid = !empty;
`endif

  // Payload is forced to zero whenever no beat is offered.
  for (genvar gi = 0; gi < TDATA_BYTES; gi++) begin : g_lane
    assign m_axis.tdata[gi*8 +: 8] = m_axis.tvalid ? rd_beat.data[gi*8 +: 8] : 8'h00;
    assign m_axis.tstrb[gi]        = m_axis.tvalid && rd_beat.strb[gi];
    assign m_axis.tkeep[gi]        = m_axis.tvalid && rd_beat.keep[gi];
  end

  assign m_axis.tlast = m_axis.tvalid && rd_beat.last;
  assign m_axis.tid   = rd_beat.id   & {TID_BITS{m_axis.tvalid}};
  assign m_axis.tdest = rd_beat.dest & {TDEST_BITS{m_axis.tvalid}};
  assign m_axis.tuser = rd_beat.user & {TUSER_BITS{m_axis.tvalid}};

endmodule
